joy_db15_responder: RTL and testbench

JOY_DB15_RESPONDER -- requirements
Module: joy_db15_responder

---
 rtl/joy_db15_responder_if.sv | 13 +
 rtl/joy_db15_responder.sv | 145 ++++++++++++++
 tb/tb_joy_db15_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/joy_db15_responder_if.sv
// Serial link between the host reader and the DB15 joystick responder.
//   JOY_CLK  : shift clock driven by the host, asynchronous to the responder clock
//   JOY_LOAD : active-low parallel-load strobe driven by the host
//   JOY_DATA : serial button data returned to the host, active-low buttons
// master = host reader side, slave = responder side.
interface joy_db15_responder_if;
   logic JOY_CLK;
   logic JOY_LOAD;
   logic JOY_DATA;

   modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
   modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/joy_db15_responder.sv
// DB15 joystick responder: presents two 16-bit button words to a host reader
// as a 32-bit active-low serial frame, player 1 first, MSB first.
// Ports:
//   clk        : system clock, the only clock domain
//   reset      : asynchronous active-high reset (release synchronized to clk)
//   joystick1  : player-1 buttons, active-high
//   joystick2  : player-2 buttons, active-high
//   joy        : host serial link (JOY_CLK, JOY_LOAD in; JOY_DATA out)
//   frame_done : one-cycle pulse when the 32nd bit has been shifted out
//   overrun    : sticky, a shift arrived after the frame ended; cleared by load
//   bit_cnt    : shifts since the last load, saturating at 32
// Parameter FILT (1..15): cycles a synchronized input must hold a new level
// before the filtered copy follows it.
module joy_db15_responder #(
   parameter int unsigned FILT = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [15:0]                joystick1,
   input  logic [15:0]                joystick2,
   joy_db15_responder_if.slave        joy,
   output logic                       frame_done,
   output logic                       overrun,
   output logic [5:0]                 bit_cnt
);

   // Reset: asserts asynchronously, releases on a clk edge.
   logic rst_meta_q;
   logic rst_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_meta_q <= 1'b1;
         rst_q      <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_q      <= rst_meta_q;
      end
   end

   // Input conditioning, index 0 = JOY_CLK, index 1 = JOY_LOAD.
   logic [1:0]      meta_q;
   logic [1:0]      sync_q;
   logic [1:0]      filt_q;
   logic [1:0]      filt_d;
   logic [1:0]      filt_dly_q;
   logic [1:0][3:0] stab_q;
   logic [1:0][3:0] stab_d;

   // stab counts consecutive cycles the synchronized level differs from the
   // filtered level; the filtered level flips on the FILT-th such cycle.
   always_comb begin
      filt_d = filt_q;
      stab_d = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         if (sync_q[i] != filt_q[i]) begin
            if (stab_q[i] == 4'(FILT - 1)) begin
               filt_d[i] = sync_q[i];
            end else begin
               stab_d[i] = stab_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst_q) begin
      if (rst_q) begin
         meta_q     <= '1;
         sync_q     <= '1;
         filt_q     <= '1;
         filt_dly_q <= '1;
         stab_q     <= '0;
      end else begin
         meta_q     <= {joy.JOY_LOAD, joy.JOY_CLK};
         sync_q     <= meta_q;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         stab_q     <= stab_d;
      end
   end

   logic clk_f;
   logic load_f;
   logic clk_rise;
   logic load_rise;

   assign clk_f     = filt_q[0];
   assign load_f    = filt_q[1];
   assign clk_rise  = clk_f & ~filt_dly_q[0];
   assign load_rise = load_f & ~filt_dly_q[1];

   // Frame engine.
   logic [31:0] sr_q,         sr_d;
   logic [5:0]  bit_cnt_q,    bit_cnt_d;
   logic        overrun_q,    overrun_d;
   logic        frame_done_q, frame_done_d;
   logic        armed_q,      armed_d;

   // armed blocks shifting after reset until a load has been seen; the filter
   // resets to idle-high so load_f alone cannot tell a fresh frame exists.
   always_comb begin
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      overrun_d    = overrun_q;
      frame_done_d = 1'b0;
      armed_d      = armed_q;
      if (!load_f) begin
         sr_d      = {~joystick1, ~joystick2};
         bit_cnt_d = '0;
         overrun_d = 1'b0;
         armed_d   = 1'b1;
      end else if (clk_rise && armed_q && !load_rise) begin
         // After 32 shifts sr is all ones, so shifting on keeps JOY_DATA high.
         sr_d = {sr_q[30:0], 1'b1};
         if (bit_cnt_q == 6'd32) begin
            overrun_d = 1'b1;
         end else begin
            bit_cnt_d    = bit_cnt_q + 6'd1;
            frame_done_d = (bit_cnt_q == 6'd31);
         end
      end
   end

   always_ff @(posedge clk or posedge rst_q) begin
      if (rst_q) begin
         sr_q         <= '1;
         bit_cnt_q    <= '0;
         overrun_q    <= 1'b0;
         frame_done_q <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         overrun_q    <= overrun_d;
         frame_done_q <= frame_done_d;
         armed_q      <= armed_d;
      end
   end

   assign joy.JOY_DATA = sr_q[31];
   assign frame_done   = frame_done_q;
   assign overrun      = overrun_q;
   assign bit_cnt      = bit_cnt_q;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Bench for joy_db15_responder: two instances (FILT=2 and FILT=3) share one
// host stimulus; a frame-level model predicts the serial bits and status.
module tb_joy_db15_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] j1, j2;
   logic        joy_clk, joy_load;

   logic        fd2, fd3, ov2, ov3;
   logic [5:0]  bc2, bc3;

   joy_db15_responder_if if2 ();
   joy_db15_responder_if if3 ();

   assign if2.JOY_CLK  = joy_clk;
   assign if2.JOY_LOAD = joy_load;
   assign if3.JOY_CLK  = joy_clk;
   assign if3.JOY_LOAD = joy_load;

   joy_db15_responder #(.FILT(2)) u2 (
      .clk(clk), .reset(reset), .joystick1(j1), .joystick2(j2), .joy(if2.slave),
      .frame_done(fd2), .overrun(ov2), .bit_cnt(bc2));

   joy_db15_responder #(.FILT(3)) u3 (
      .clk(clk), .reset(reset), .joystick1(j1), .joystick2(j2), .joy(if3.slave),
      .frame_done(fd3), .overrun(ov3), .bit_cnt(bc3));

   always #5 clk = ~clk;

   // frame_done high-cycle counters
   int fdc2 = 0, fdc3 = 0;
   always @(negedge clk) begin
      if (fd2) fdc2++;
      if (fd3) fdc3++;
   end

   int n_tot = 0, n_pass = 0, n_fail = 0;

   // Model: captured word, shifts accepted per instance, armed-after-load flag.
   logic [31:0] word;
   int          k2, k3, efd2, efd3;
   bit          armed;

   function automatic logic exp_data(input logic [31:0] w, input int k);
      logic [31:0] t;
      t = w;
      return (k < 32) ? t[31-k] : 1'b1;
   endfunction

   function automatic int exp_cnt(input int k);
      return (k > 32) ? 32 : k;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " data f2"}, 32'(if2.JOY_DATA), 32'(exp_data(word, k2)));
      chk({tag, " cnt f2"},  32'(bc2), 32'(exp_cnt(k2)));
      chk({tag, " ovr f2"},  32'(ov2), 32'(k2 > 32));
      chk({tag, " fd f2"},   32'(fdc2), 32'(efd2));
      chk({tag, " data f3"}, 32'(if3.JOY_DATA), 32'(exp_data(word, k3)));
      chk({tag, " cnt f3"},  32'(bc3), 32'(exp_cnt(k3)));
      chk({tag, " ovr f3"},  32'(ov3), 32'(k3 > 32));
      chk({tag, " fd f3"},   32'(fdc3), 32'(efd3));
   endtask

   task automatic acc2();
      k2++;
      if (k2 == 32) efd2++;
   endtask

   task automatic acc3();
      k3++;
      if (k3 == 32) efd3++;
   endtask

   // Full-width host clock pulse with random high/low widths.
   task automatic pulse(input string tag);
      int h, l;
      h = $urandom_range(6, 10);
      l = $urandom_range(6, 10);
      joy_clk = 1'b1;
      cyc(h);
      if (armed) begin
         acc2();
         acc3();
      end
      joy_clk = 1'b0;
      cyc(l);
      check_all(tag);
   endtask

   // Short high pulse of n cycles: accepted only when n reaches FILT.
   task automatic glitch(input int n, input string tag);
      joy_clk = 1'b1;
      cyc(n);
      joy_clk = 1'b0;
      cyc(8);
      if (armed && n >= 2) acc2();
      if (armed && n >= 3) acc3();
      check_all(tag);
   endtask

   task automatic do_load(input string tag);
      joy_load = 1'b0;
      cyc(10);
      word  = {~j1, ~j2};
      k2    = 0;
      k3    = 0;
      armed = 1'b1;
      check_all(tag);
      joy_load = 1'b1;
      cyc(8);
   endtask

   initial begin
      logic [31:0] ser;
      reset    = 1'b1;
      joy_clk  = 1'b0;
      joy_load = 1'b1;
      j1       = 16'h0011;
      j2       = 16'h0200;
      word     = '1;
      k2 = 0; k3 = 0; efd2 = 0; efd3 = 0;
      armed    = 1'b0;
      cyc(5);
      check_all("reset");
      reset = 1'b0;
      cyc(5);
      check_all("post-reset");

      // Basic frame with fixed buttons; also gather the serial stream.
      do_load("load1");
      ser = '0;
      for (int i = 0; i < 32; i++) begin
         ser = {ser[30:0], if2.JOY_DATA};
         pulse("frame1");
      end
      chk("serial stream", ser, 32'hFFEEFDFF);

      // Overrun, then cleared by load.
      pulse("overrun");
      pulse("overrun2");
      do_load("load clears ovr");

      // Random frames; second one changes joystick1 mid-frame.
      for (int f = 0; f < 2; f++) begin
         j1 = 16'($urandom);
         j2 = 16'($urandom);
         do_load("rload");
         for (int i = 0; i < 32; i++) begin
            if (f == 1 && i == 5) begin
               j1 = ~j1;
               j2 = 16'($urandom);
            end
            pulse("rframe");
         end
      end

      // Glitch rejection.
      j1 = 16'($urandom);
      j2 = 16'($urandom);
      do_load("gload");
      glitch(1, "glitch1");
      glitch(2, "glitch2");
      glitch(3, "glitch3");

      // Clock edge coincident with load falling: load wins.
      joy_clk  = 1'b1;
      joy_load = 1'b0;
      j1 = 16'($urandom);
      cyc(10);
      word = {~j1, ~j2};
      k2 = 0; k3 = 0;
      check_all("load priority");
      joy_load = 1'b1;
      cyc(8);
      joy_clk = 1'b0;
      cyc(8);
      check_all("load priority rel");

      // Clock edge coincident with load rising: discarded.
      joy_load = 1'b0;
      cyc(10);
      joy_load = 1'b1;
      joy_clk  = 1'b1;
      cyc(8);
      joy_clk  = 1'b0;
      cyc(8);
      check_all("edge at load rise");
      pulse("after load rise");

      // Reset mid-frame.
      do_load("mload");
      for (int i = 0; i < 12; i++) pulse("mframe");
      reset = 1'b1;
      #1;
      word  = '1;
      k2 = 0; k3 = 0;
      armed = 1'b0;
      check_all("async reset");
      cyc(3);
      reset = 1'b0;
      cyc(5);
      pulse("unarmed1");
      pulse("unarmed2");
      j1 = 16'($urandom);
      j2 = 16'($urandom);
      do_load("reload");
      for (int i = 0; i < 32; i++) pulse("post-reset frame");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
